// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of a PWM line in clock cycles.
// Optional 2-flop input synchroniser selected by PWM_CAPTURE_SYNC_EN.
module pwm_capture #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_in,
    output logic [W-1:0] io_period,
    output logic [W-1:0] io_high,
    output logic         io_valid,
    output logic         io_timeout,
    output logic         io_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    state_t       state_r;
    state_t       state_nxt_s;
    logic [W-1:0] cnt_r;
    logic [W-1:0] hcnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic [W-1:0] hcnt_nxt_s;
    logic [W-1:0] period_nxt_s;
    logic [W-1:0] high_nxt_s;
    logic         valid_nxt_s;
    logic         timeout_nxt_s;
    logic         prev_r;
    logic         in_s;
    logic         rise_s;
    logic         fall_s;
    logic         timeout_s;

`ifdef PWM_CAPTURE_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchroniser; resets high so a high line is not seen as a rise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= io_in;
            sync2_r <= sync1_r;
        end
    end

    assign in_s = sync2_r;
`else
    assign in_s = io_in;
`endif

    assign rise_s    = in_s & ~prev_r;
    assign fall_s    = ~in_s & prev_r;
    // A rise at the last count is still a valid measurement.
    assign timeout_s = (state_r != IDLE) && (cnt_r == CNT_MAX) && !rise_s;

    // State register with busy flag registered alongside it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            io_busy <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            io_busy <= (state_nxt_s != IDLE);
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) state_nxt_s = HIGH;
                else        state_nxt_s = IDLE;
            end
            HIGH: begin
                if (timeout_s)   state_nxt_s = IDLE;
                else if (fall_s) state_nxt_s = LOW;
                else             state_nxt_s = HIGH;
            end
            LOW: begin
                if (timeout_s)   state_nxt_s = IDLE;
                else if (rise_s) state_nxt_s = HIGH;
                else             state_nxt_s = LOW;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Counter and output next values per state.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        hcnt_nxt_s    = hcnt_r;
        period_nxt_s  = io_period;
        high_nxt_s    = io_high;
        valid_nxt_s   = 1'b0;
        timeout_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    cnt_nxt_s  = CNT_ONE;
                    hcnt_nxt_s = CNT_ONE;
                end else begin
                    cnt_nxt_s  = CNT_ZERO;
                    hcnt_nxt_s = CNT_ZERO;
                end
            end
            HIGH: begin
                if (timeout_s) begin
                    cnt_nxt_s     = CNT_ZERO;
                    hcnt_nxt_s    = CNT_ZERO;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s  = cnt_r + CNT_ONE;
                    hcnt_nxt_s = hcnt_r + {{(W-1){1'b0}}, in_s};
                end
            end
            LOW: begin
                if (timeout_s) begin
                    cnt_nxt_s     = CNT_ZERO;
                    hcnt_nxt_s    = CNT_ZERO;
                    timeout_nxt_s = 1'b1;
                end else if (rise_s) begin
                    period_nxt_s = cnt_r;
                    high_nxt_s   = hcnt_r;
                    valid_nxt_s  = 1'b1;
                    cnt_nxt_s    = CNT_ONE;
                    hcnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_nxt_s  = CNT_ZERO;
                hcnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // Datapath and registered outputs; prev resets high to ignore an already-high line.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r      <= CNT_ZERO;
            hcnt_r     <= CNT_ZERO;
            prev_r     <= 1'b1;
            io_period  <= CNT_ZERO;
            io_high    <= CNT_ZERO;
            io_valid   <= 1'b0;
            io_timeout <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            hcnt_r     <= hcnt_nxt_s;
            prev_r     <= in_s;
            io_period  <= period_nxt_s;
            io_high    <= high_nxt_s;
            io_valid   <= valid_nxt_s;
            io_timeout <= timeout_nxt_s;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed patterns plus random PWM,
// compared each cycle against a time-stamp based reference model.
module tb_pwm_capture;

    localparam int W    = 8;
    localparam int MAXP = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset;
    logic         io_in;
    logic [W-1:0] io_period;
    logic [W-1:0] io_high;
    logic         io_valid;
    logic         io_timeout;
    logic         io_busy;

    int errors = 0;
    int checks = 0;

    // Reference model: measurement derived from rising-edge time stamps.
    bit m_prev, m_d1, m_d2, m_armed, m_valid, m_timeout;
    int m_t, m_last_rise, m_high, m_period, m_highout;

    pwm_capture #(.W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .io_in     (io_in),
        .io_period (io_period),
        .io_high   (io_high),
        .io_valid  (io_valid),
        .io_timeout(io_timeout),
        .io_busy   (io_busy)
    );

    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic check_all();
        check_bit("valid",   io_valid,   m_valid);
        check_bit("timeout", io_timeout, m_timeout);
        check_bit("busy",    io_busy,    m_armed);
        check_vec("period",  io_period,  W'(m_period));
        check_vec("high",    io_high,    W'(m_highout));
    endtask

    task automatic model_reset();
        m_prev = 1'b1; m_d1 = 1'b1; m_d2 = 1'b1;
        m_armed = 1'b0; m_valid = 1'b0; m_timeout = 1'b0;
        m_period = 0; m_highout = 0; m_high = 0;
    endtask

    task automatic model_step(input bit raw);
        bit v;
        bit rise;
        int el;
`ifdef PWM_CAPTURE_SYNC_EN
        v = m_d2; m_d2 = m_d1; m_d1 = raw;
`else
        v = raw;
`endif
        m_t++;
        m_valid = 1'b0;
        m_timeout = 1'b0;
        rise = v && !m_prev;
        if (m_armed) begin
            el = m_t - m_last_rise;
            if (rise) begin
                m_period = el; m_highout = m_high; m_valid = 1'b1;
                m_last_rise = m_t; m_high = 1;
            end else if (el >= MAXP) begin
                m_armed = 1'b0; m_timeout = 1'b1;
            end else begin
                m_high += int'(v);
            end
        end else if (rise) begin
            m_armed = 1'b1; m_last_rise = m_t; m_high = 1;
        end
        m_prev = v;
    endtask

    task automatic cycle(input bit v);
        @(negedge clock);
        io_in = v;
        reset = 1'b1;
        @(posedge clock);
        model_step(v);
        #1 check_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        model_reset();
        #1 check_all();
    endtask

    task automatic pwm(input int h, input int l, input int n);
        for (int p = 0; p < n; p++) begin
            repeat (h) cycle(1'b1);
            repeat (l) cycle(1'b0);
        end
    endtask

    initial begin
        reset = 1'b0;
        io_in = 1'b1;
        m_t = 0;
        model_reset();
        do_reset();
        do_reset();

        // Line high out of reset: never leaves IDLE.
        repeat (300) cycle(1'b1);
        check_bit("stuck_high_busy", io_busy, 1'b0);

        // Locked 6/5 pattern.
        pwm(6, 5, 6);
        check_vec("p65_period", io_period, 8'd11);
        check_vec("p65_high",   io_high,   8'd6);

        // Stuck low after lock: timeout, values retained.
        repeat (300) cycle(1'b0);
        check_bit("timeout_busy",   io_busy,   1'b0);
        check_vec("timeout_period", io_period, 8'd11);
        check_vec("timeout_high",   io_high,   8'd6);

        // Longest measurable period: 1 high / 254 low.
        pwm(1, 254, 3);
        repeat (3) cycle(1'b1);
        check_vec("max_period", io_period, 8'd255);
        check_vec("max_high",   io_high,   8'd1);

        // Reset in the middle of a 6/5 period.
        repeat (5) cycle(1'b0);
        pwm(6, 5, 3);
        repeat (3) cycle(1'b1);
        do_reset();
        check_vec("rst_period", io_period, 8'd0);
        check_vec("rst_high",   io_high,   8'd0);
        check_bit("rst_busy",   io_busy,   1'b0);
        repeat (3) cycle(1'b1);
        pwm(0, 5, 1);
        pwm(6, 5, 4);

        // Randomized PWM with occasional long low phases and resets.
        for (int i = 0; i < 80; i++) begin
            int h;
            int l;
            h = int'($urandom_range(1, 30));
            l = int'($urandom_range(1, 30));
            if ($urandom_range(0, 9) == 0) l = int'($urandom_range(240, 270));
            if ($urandom_range(0, 9) == 0) h = int'($urandom_range(240, 270));
            pwm(h, l, 1);
            if ($urandom_range(0, 14) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
